// File: rtl/led_div_seq_pkg.sv
// Shared types and defaults for the LED divider sequencer.
package led_div_seq_pkg;

    localparam int unsigned DIVW_DEFAULT = 5;
    localparam int unsigned DWW_DEFAULT  = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StDwell = 2'd2
    } seq_state_t;

    // Table entry at the default widths; the top builds the same shape from its parameters.
    typedef struct packed {
        logic [DIVW_DEFAULT-1:0] div;
        logic [DWW_DEFAULT-1:0]  dwell;
    } seq_entry_t;

endpackage

// File: rtl/led_div_seq_if.sv
// Register-style table write port for the divider sequencer.
interface led_div_seq_if #(
    parameter int unsigned AW   = 3,
    parameter int unsigned DIVW = 5,
    parameter int unsigned DWW  = 16
) ();

    logic            cfg_wr;
    logic [AW-1:0]   cfg_addr;
    logic [DIVW-1:0] cfg_div;
    logic [DWW-1:0]  cfg_dwell;

    modport master (
        output cfg_wr,
        output cfg_addr,
        output cfg_div,
        output cfg_dwell
    );

    modport slave (
        input cfg_wr,
        input cfg_addr,
        input cfg_div,
        input cfg_dwell
    );

endinterface

// File: rtl/led_div_seq_tick_gen.sv
// Dwell-unit prescaler: one tick every PRESC cycles, phase restarted by restart_i.
module led_div_seq_tick_gen #(
    parameter int unsigned PRESC = 100000
) (
    input  logic clk100,
    input  logic rstn,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned PW = $clog2(PRESC);

    logic [PW-1:0] cnt_q, cnt_d;

    // Restart loads 1 so the restart cycle itself counts as the first cycle of the unit.
    always_comb begin
        cnt_d = cnt_q + PW'(1);
        if (restart_i) begin
            cnt_d = PW'(1);
        end else if (cnt_q == PW'(PRESC - 1)) begin
            cnt_d = '0;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !restart_i && (cnt_q == PW'(PRESC - 1));

endmodule

// File: rtl/led_div_seq.sv
// Divider sequencer: plays a table of {div, dwell} entries into led_cnt's div/wren inputs.
module led_div_seq
    import led_div_seq_pkg::*;
#(
    parameter int unsigned DIVW  = DIVW_DEFAULT,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DWW   = DWW_DEFAULT,
    parameter int unsigned PRESC = 100000,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
    input  logic            clk100,
    input  logic            rstn,
    input  logic            en_i,
    input  logic [LW-1:0]   len_i,
    led_div_seq_if.slave    cfg_bus,
    output logic [DIVW-1:0] div_o,
    output logic            wren_o,
    output logic [AW-1:0]   step_o,
    output logic            busy_o
);

    typedef struct packed {
        logic [DIVW-1:0] div;
        logic [DWW-1:0]  dwell;
    } entry_t;

    entry_t          tbl_q [DEPTH];
    entry_t          ld_entry;
    seq_state_t      state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [DWW-1:0]  dcnt_q, dcnt_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [AW-1:0]   step_q, step_d;
    logic            wren_q, wren_d;
    logic            restart;
    logic            tick;
    logic [LW-1:0]   len_c;
    logic            wrap;

    led_div_seq_tick_gen #(
        .PRESC(PRESC)
    ) u_tick_gen (
        .clk100   (clk100),
        .rstn     (rstn),
        .restart_i(restart),
        .tick_o   (tick)
    );

    // Table storage; writes never touch the running dwell count.
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tbl_q[i] <= '0;
            end
        end else if (cfg_bus.cfg_wr) begin
            tbl_q[cfg_bus.cfg_addr] <= {cfg_bus.cfg_div, cfg_bus.cfg_dwell};
        end
    end

    // Entry to load, with write-first bypass when the same entry is written this cycle.
    always_comb begin
        ld_entry = tbl_q[idx_q];
        if (cfg_bus.cfg_wr && (cfg_bus.cfg_addr == idx_q)) begin
            ld_entry = {cfg_bus.cfg_div, cfg_bus.cfg_dwell};
        end
    end

    // Active length clamp and wrap decision for the step after the current one.
    always_comb begin
        len_c = (len_i > LW'(DEPTH)) ? LW'(DEPTH) : len_i;
        wrap  = (LW'(idx_q) + LW'(1)) >= len_c;
    end

    // Next-state and output-register logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dcnt_d  = dcnt_q;
        div_d   = div_q;
        step_d  = step_q;
        wren_d  = 1'b0;
        restart = 1'b0;
        if (!en_i) begin
            // Disable wins in any state; div/step hold for the LED.
            state_d = StIdle;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (len_c != '0) begin
                        state_d = StLoad;
                        idx_d   = '0;
                    end
                end
                StLoad: begin
                    div_d   = ld_entry.div;
                    step_d  = idx_q;
                    wren_d  = 1'b1;
                    dcnt_d  = (ld_entry.dwell == '0) ? DWW'(1) : ld_entry.dwell;
                    restart = 1'b1;
                    state_d = StDwell;
                end
                StDwell: begin
                    if (tick) begin
                        if (dcnt_q <= DWW'(1)) begin
                            if (len_c == '0) begin
                                state_d = StIdle;
                                idx_d   = '0;
                            end else begin
                                state_d = StLoad;
                                idx_d   = wrap ? '0 : idx_q + AW'(1);
                            end
                        end else begin
                            dcnt_d = dcnt_q - DWW'(1);
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // FSM, dwell counter and output registers.
    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            idx_q   <= '0;
            dcnt_q  <= '0;
            div_q   <= '0;
            step_q  <= '0;
            wren_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dcnt_q  <= dcnt_d;
            div_q   <= div_d;
            step_q  <= step_d;
            wren_q  <= wren_d;
        end
    end

    assign div_o  = div_q;
    assign wren_o = wren_q;
    assign step_o = step_q;
    assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_led_div_seq.sv
// Directed bench for led_div_seq with PRESC=4, DEPTH=8.
module tb_led_div_seq;

    localparam int unsigned DIVW  = 5;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned DWW   = 16;
    localparam int unsigned PRESC = 4;
    localparam int unsigned AW    = 3;
    localparam int unsigned LW    = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            en_i = 1'b0;
    logic [LW-1:0]   len_i = '0;
    logic [DIVW-1:0] div_o;
    logic            wren_o;
    logic [AW-1:0]   step_o;
    logic            busy_o;

    led_div_seq_if #(.AW(AW), .DIVW(DIVW), .DWW(DWW)) cfg_if ();

    led_div_seq #(
        .DIVW (DIVW),
        .DEPTH(DEPTH),
        .DWW  (DWW),
        .PRESC(PRESC)
    ) dut (
        .clk100 (clk),
        .rstn   (rstn),
        .en_i   (en_i),
        .len_i  (len_i),
        .cfg_bus(cfg_if),
        .div_o  (div_o),
        .wren_o (wren_o),
        .step_o (step_o),
        .busy_o (busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int q_cyc[$];
    int q_div[$];
    int q_step[$];

    // Pulse logger: values seen here are those of the cycle just ending.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wren_o) begin
            q_cyc.push_back(cyc);
            q_div.push_back(int'(div_o));
            q_step.push_back(int'(step_o));
        end
    end

    task automatic clear_q();
        q_cyc.delete();
        q_div.delete();
        q_step.delete();
    endtask

    task automatic cfg_write(input int a, input int d, input int w);
        @(negedge clk);
        cfg_if.cfg_wr    = 1'b1;
        cfg_if.cfg_addr  = AW'(a);
        cfg_if.cfg_div   = DIVW'(d);
        cfg_if.cfg_dwell = DWW'(w);
        @(negedge clk);
        cfg_if.cfg_wr    = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        while (q_cyc.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (div_o !== '0) begin fails++; $display("FAIL reset_div got=%0d exp=0", div_o); end
        checks++; if (wren_o !== 1'b0) begin fails++; $display("FAIL reset_wren got=%b exp=0", wren_o); end
        checks++; if (step_o !== '0) begin fails++; $display("FAIL reset_step got=%0d exp=0", step_o); end
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        rstn  = 1'b1;
        len_i = '0;
        en_i  = 1'b1;
        clear_q();
        repeat (20) @(negedge clk);
        checks++; if (q_cyc.size() != 0) begin fails++; $display("FAIL len0_pulses got=%0d exp=0", q_cyc.size()); end
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL len0_busy got=%b exp=0", busy_o); end
        checks++; if (div_o !== '0) begin fails++; $display("FAIL len0_div got=%0d exp=0", div_o); end
        en_i = 1'b0;
    endtask

    task automatic test_sequence();
        int exp_div[4]  = '{3, 10, 3, 10};
        int exp_step[4] = '{0, 1, 0, 1};
        int exp_gap[3]  = '{8, 4, 8};
        cfg_write(0, 3, 2);
        cfg_write(1, 10, 1);
        len_i = LW'(2);
        clear_q();
        en_i = 1'b1;
        wait_pulses(4, 60);
        checks++;
        if (q_cyc.size() < 4) begin
            fails++; $display("FAIL seq_count got=%0d exp=4", q_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q_div[i] != exp_div[i]) begin fails++; $display("FAIL seq_div[%0d] got=%0d exp=%0d", i, q_div[i], exp_div[i]); end
                checks++;
                if (q_step[i] != exp_step[i]) begin fails++; $display("FAIL seq_step[%0d] got=%0d exp=%0d", i, q_step[i], exp_step[i]); end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_cyc[i+1] - q_cyc[i] != exp_gap[i]) begin
                    fails++; $display("FAIL seq_gap[%0d] got=%0d exp=%0d", i, q_cyc[i+1] - q_cyc[i], exp_gap[i]);
                end
            end
        end
        en_i = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_dwell_zero();
        cfg_write(0, 6, 0);
        len_i = LW'(1);
        clear_q();
        en_i = 1'b1;
        wait_pulses(4, 40);
        checks++;
        if (q_cyc.size() < 4) begin
            fails++; $display("FAIL dw0_count got=%0d exp=4", q_cyc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q_div[i] != 6 || q_step[i] != 0) begin
                    fails++; $display("FAIL dw0_entry[%0d] got div=%0d step=%0d exp div=6 step=0", i, q_div[i], q_step[i]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (q_cyc[i+1] - q_cyc[i] != 4) begin
                    fails++; $display("FAIL dw0_gap[%0d] got=%0d exp=4", i, q_cyc[i+1] - q_cyc[i]);
                end
            end
        end
        en_i = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_disable();
        int budget = 60;
        cfg_write(0, 3, 2);
        len_i = LW'(2);
        en_i  = 1'b1;
        @(negedge clk);
        while (!(wren_o === 1'b1 && step_o === AW'(1)) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (budget == 0) begin fails++; $display("FAIL dis_reach_step1 got=timeout exp=pulse"); end
        en_i = 1'b0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL dis_busy got=%b exp=0", busy_o); end
        clear_q();
        repeat (10) @(negedge clk);
        checks++; if (q_cyc.size() != 0) begin fails++; $display("FAIL dis_pulses got=%0d exp=0", q_cyc.size()); end
        checks++; if (div_o !== DIVW'(10)) begin fails++; $display("FAIL dis_div_hold got=%0d exp=10", div_o); end
        checks++; if (step_o !== AW'(1)) begin fails++; $display("FAIL dis_step_hold got=%0d exp=1", step_o); end
        en_i = 1'b1;
        wait_pulses(1, 20);
        checks++;
        if (q_cyc.size() < 1) begin
            fails++; $display("FAIL reen_count got=0 exp=1");
        end else if (q_step[0] != 0 || q_div[0] != 3) begin
            fails++; $display("FAIL reen_first got step=%0d div=%0d exp step=0 div=3", q_step[0], q_div[0]);
        end
        en_i = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_bypass();
        @(negedge clk);
        en_i = 1'b1;
        @(negedge clk);
        checks++; if (busy_o !== 1'b1) begin fails++; $display("FAIL byp_load_busy got=%b exp=1", busy_o); end
        cfg_if.cfg_wr    = 1'b1;
        cfg_if.cfg_addr  = '0;
        cfg_if.cfg_div   = DIVW'(7);
        cfg_if.cfg_dwell = DWW'(1);
        @(negedge clk);
        cfg_if.cfg_wr = 1'b0;
        checks++; if (wren_o !== 1'b1) begin fails++; $display("FAIL byp_wren got=%b exp=1", wren_o); end
        checks++; if (div_o !== DIVW'(7)) begin fails++; $display("FAIL byp_div got=%0d exp=7", div_o); end
        checks++; if (step_o !== '0) begin fails++; $display("FAIL byp_step got=%0d exp=0", step_o); end
        en_i = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_wrap_and_reset();
        int budget = 20;
        for (int i = 0; i < 8; i++) cfg_write(i, 16 + i, 0);
        len_i = LW'(12);
        clear_q();
        en_i = 1'b1;
        wait_pulses(10, 80);
        checks++;
        if (q_cyc.size() < 10) begin
            fails++; $display("FAIL wrap_count got=%0d exp=10", q_cyc.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (q_step[i] != i % 8 || q_div[i] != 16 + i % 8) begin
                    fails++; $display("FAIL wrap_entry[%0d] got step=%0d div=%0d exp step=%0d div=%0d",
                                      i, q_step[i], q_div[i], i % 8, 16 + i % 8);
                end
            end
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (q_cyc[i+1] - q_cyc[i] != 4) begin
                    fails++; $display("FAIL wrap_gap[%0d] got=%0d exp=4", i, q_cyc[i+1] - q_cyc[i]);
                end
            end
        end
        while (wren_o !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (budget == 0) begin fails++; $display("FAIL rst_reach_pulse got=timeout exp=pulse"); end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if (div_o !== '0 || wren_o !== 1'b0 || step_o !== '0 || busy_o !== 1'b0) begin
            fails++; $display("FAIL midrun_reset got div=%0d wren=%b step=%0d busy=%b exp all 0",
                              div_o, wren_o, step_o, busy_o);
        end
        en_i = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        clear_q();
        repeat (8) @(negedge clk);
        checks++; if (q_cyc.size() != 0) begin fails++; $display("FAIL release_pulses got=%0d exp=0", q_cyc.size()); end
        checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL release_busy got=%b exp=0", busy_o); end
        len_i = LW'(1);
        en_i  = 1'b1;
        wait_pulses(1, 20);
        checks++;
        if (q_cyc.size() < 1) begin
            fails++; $display("FAIL tbl_cleared_count got=0 exp=1");
        end else if (q_div[0] != 0) begin
            fails++; $display("FAIL tbl_cleared_div got=%0d exp=0", q_div[0]);
        end
        en_i = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        cfg_if.cfg_wr    = 1'b0;
        cfg_if.cfg_addr  = '0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_dwell = '0;
        test_reset();
        test_sequence();
        test_dwell_zero();
        test_disable();
        test_bypass();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
